clk_step_ctrl: RTL and testbench
================================

Name: clk_step_ctrl

Overview:
- Run/step controller for the lab CPU clocking path.
- Takes the 60 MHz system clock and board controls (mode switches, step button, halt from core).
- Produces a single-cycle core enable pulse at a selectable division rate, or one pulse per debounced button press.
- Also sequences a delayed core reset release and counts issued enables for display.

Parameters:
- SLOW_LOG2, 20, log2 of slowest division period (2^20 cycles ≈ 57 Hz at 60 MHz); must be ≥ 10.
- DEB_CYCLES, 600000, cycles the synchronised button must be stable before a level change is accepted (10 ms).
- RST_HOLD, 16, cycles core_rst_n stays low after rst deasserts.

Ports:
- clk, input, 1, system clock 60 MHz.
- rst, input, 1, reset, synchronous, active-low.
- mode, input, 2, 00 halt, 01 run, 10 step, 11 treated as halt.
- div_sel, input, 2, run rate: 00 period 2, 01 period 32, 10 period 512, 11 period 2^SLOW_LOG2.
- step_btn, input, 1, raw asynchronous push button, active-high.
- halt_req, input, 1, core halt request, level, synchronous to clk.
- core_en, output, 1, single-cycle enable to core registers.
- core_rst_n, output, 1, core reset, active-low, registered.
- state, output, 2, 00 RESET, 01 HALT, 10 RUN, 11 STEP.
- halted, output, 1, sticky flag: core requested halt.
- en_cnt, output, 32, number of core_en pulses since reset, wraps at 2^32.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=RESET, core_en=0, core_rst_n=0, halted=0, en_cnt=0.
  - Prescaler, hold counter, debouncer and synchronisers all cleared.
  - Applies mid-operation on the same edge, with no partial pulses.
- Reset sequencer:
  - After rst=1, the hold counter counts RST_HOLD cycles.
  - core_rst_n rises on the cycle state leaves RESET for HALT.
  - core_en is 0 whenever core_rst_n=0.
- Prescaler:
  - Free-running SLOW_LOG2-bit counter, starts at 0 when RESET exits.
  - tick=1 when the low k bits are all ones, with k=1/5/9/SLOW_LOG2 per div_sel.
  - Steady-state period is exactly 2^k cycles.
  - A div_sel change takes effect on the next compare; the counter is not restarted.
- Step input path:
  - step_btn passes through a 2-flop synchroniser.
  - The debouncer accepts the new level after DEB_CYCLES consecutive equal samples.
  - Rising edge of the debounced level gives step_evt, a 1-cycle pulse.
  - Presses during RESET are discarded.
- FSM, registered, evaluated every cycle:
  - RESET -> HALT when the hold counter reaches RST_HOLD.
  - HALT -> RUN when mode=01 and halted=0.
  - HALT -> STEP when mode=10 and step_evt=1 and halted=0.
  - RUN -> HALT when mode≠01 or halt_req=1. The transition cycle emits no core_en, even if tick=1.
  - STEP -> HALT always, after exactly one cycle.
  - Priority within a cycle: rst > halt_req > mode.
- Outputs and flags:
  - core_en is registered: 1 for the cycle after a qualifying condition.
  - Qualifying condition: (state=RUN and tick and no exit) or (state=STEP).
  - Latency from tick or step entry to core_en: 1 cycle.
  - halted: set when halt_req=1 in RUN or STEP; cleared only when mode=00. While set, HALT never exits.
  - en_cnt increments on every cycle core_en=1.
- Simultaneous events:
  - halt_req with step_evt in HALT: halted is set and the step is dropped.
  - Mode change with tick in RUN: no pulse.

Decomposition:
- Shared package clk_step_pkg:
  - State encodings ST_RESET/ST_HALT/ST_RUN/ST_STEP.
  - Mode constants MODE_HALT/MODE_RUN/MODE_STEP.
  - div_sel-to-k mapping constants.
- Sub-module btn_debounce (synchroniser, stable counter, rising-edge pulse), parameterised by DEB_CYCLES.
- Prescaler, FSM and counter stay in clk_step_ctrl.

Test Plan (bench params SLOW_LOG2=10, DEB_CYCLES=4, RST_HOLD=4):
- Release rst, mode=00 -> core_rst_n=0 for 4 cycles then 1; state=01; core_en never 1.
- mode=01, div_sel=01, run 200 cycles -> core_en pulses exactly 32 cycles apart; en_cnt=6 after 200 cycles; div_sel=00 -> period becomes 2 within 2 cycles.
- mode=10, button high for 10 cycles with 1-cycle glitches before it -> exactly one core_en, state visits 11 for one cycle; a glitch pulse of 2 cycles alone -> no core_en.
- RUN with div_sel=00, assert halt_req 1 cycle -> state=01, halted=1, no further core_en; mode=01 held -> stays HALT; mode=00 then 01 -> RUN resumes.
- Drop rst mid-RUN with core_en due next cycle -> next cycle core_en=0, core_rst_n=0, en_cnt=0, state=00.
- Force en_cnt near wrap (run with bench preload via many ticks or hierarchical force to 0xFFFFFFFF) -> next pulse gives en_cnt=0.

Source files
------------

// File: rtl/clk_step_pkg.sv
// Shared encodings for the lab CPU run/step clock controller.
package clk_step_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_HALT  = 2'b01,
    ST_RUN   = 2'b10,
    ST_STEP  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // Prescaler compare widths selected by div_sel; 2'b11 uses SLOW_LOG2.
  localparam int K_DIV0 = 1;
  localparam int K_DIV1 = 5;
  localparam int K_DIV2 = 9;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability timer and
// rising-edge pulse. While clr is high the accepted level silently follows
// the synchronised input, so a press held across clr never produces a pulse.
module btn_debounce
  import clk_step_pkg::*;
#(
  parameter int DEB_CYCLES = 600000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic btn,
  output logic evt
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level after DEB_CYCLES differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      evt   <= 1'b0;
      if (clr) begin
        level <= sync2;
        cnt   <= RELOAD;
      end else if (sync2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync2;
        cnt   <= RELOAD;
        evt   <= sync2;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step controller for the lab CPU clocking path: divided or single-step
// core enable, delayed core reset release and an enable counter.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_RESET | core held in reset, hold counter running
//   ST_HALT  | core out of reset, no enables issued
//   ST_RUN   | enable on every prescaler tick
//   ST_STEP  | one enable, then back to HALT
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int SLOW_LOG2  = 20,
  parameter int DEB_CYCLES = 600000,
  parameter int RST_HOLD   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [1:0]  div_sel,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        core_en,
  output logic        core_rst_n,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] en_cnt
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [SLOW_LOG2-1:0]   ps;
  logic [SLOW_LOG2-1:0]   mask;
  logic                   tick;
  logic                   step_evt;
  logic                   run_exit;
  logic                   en_d;
  logic                   halt_set;

  assign state = state_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_RESET),
    .btn (step_btn),
    .evt (step_evt)
  );

  // Compare mask for the selected division; tick when masked bits all ones.
  always_comb begin
    mask = '1;
    case (div_sel)
      2'b00:   mask = SLOW_LOG2'((1 << K_DIV0) - 1);
      2'b01:   mask = SLOW_LOG2'((1 << K_DIV1) - 1);
      2'b10:   mask = SLOW_LOG2'((1 << K_DIV2) - 1);
      default: mask = '1;
    endcase
    tick = ((ps & mask) == mask);
  end

  // Next state, enable qualification and sticky-halt set condition.
  always_comb begin
    state_d  = state_q;
    run_exit = halt_req || (mode != MODE_RUN);
    en_d     = 1'b0;
    halt_set = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (hold_cnt == HOLD_W'(RST_HOLD)) state_d = ST_HALT;
      end
      ST_HALT: begin
        // A halt request that coincides with a run/step request wins.
        halt_set = halt_req &&
                   ((mode == MODE_RUN) || ((mode == MODE_STEP) && step_evt));
        if (!halted && !halt_req) begin
          if (mode == MODE_RUN)                     state_d = ST_RUN;
          else if ((mode == MODE_STEP) && step_evt) state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        halt_set = halt_req;
        en_d     = tick && !run_exit;
        if (run_exit) state_d = ST_HALT;
      end
      ST_STEP: begin
        halt_set = halt_req;
        en_d     = 1'b1;
        state_d  = ST_HALT;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State register and registered core-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RESET;
      core_en    <= 1'b0;
      core_rst_n <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_en    <= en_d;
      core_rst_n <= (state_d != ST_RESET);
      if (halt_set)               halted <= 1'b1;
      else if (mode == MODE_HALT) halted <= 1'b0;
    end
  end

  // Reset hold counter and free-running prescaler (held at 0 in RESET).
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      ps       <= '0;
    end else begin
      if ((state_q == ST_RESET) && (hold_cnt != HOLD_W'(RST_HOLD)))
        hold_cnt <= hold_cnt + 1'b1;
      if (state_q == ST_RESET) ps <= '0;
      else                     ps <= ps + 1'b1;
    end
  end

  // Count issued enables; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst)         en_cnt <= '0;
    else if (core_en) en_cnt <= en_cnt + 32'd1;
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with short debounce and slow divider.
module tb_clk_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  div_sel;
  logic        step_btn;
  logic        halt_req;
  logic        core_en;
  logic        core_rst_n;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] en_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  clk_step_ctrl #(.SLOW_LOG2(10), .DEB_CYCLES(4), .RST_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .div_sel    (div_sel),
    .step_btn   (step_btn),
    .halt_req   (halt_req),
    .core_en    (core_en),
    .core_rst_n (core_rst_n),
    .state      (state),
    .halted     (halted),
    .en_cnt     (en_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit ok;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    ok  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (state === 2'b01) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_exit: state=%b, required 01 within 20 cycles", state);
    end
  endtask

  task automatic test_reset();
    int bad;
    mode = 2'b00; div_sel = 2'b00; step_btn = 1'b0; halt_req = 1'b0; rst = 1'b0;
    repeat (3) tick();
    n_tests++; if (state !== 2'b00)   begin n_fail++; $display("FAIL rst_state: got %b, required 00", state); end
    n_tests++; if (core_rst_n !== 0)  begin n_fail++; $display("FAIL rst_core_rst_n: got %b, required 0", core_rst_n); end
    n_tests++; if (core_en !== 0)     begin n_fail++; $display("FAIL rst_core_en: got %b, required 0", core_en); end
    n_tests++; if (halted !== 0)      begin n_fail++; $display("FAIL rst_halted: got %b, required 0", halted); end
    n_tests++; if (en_cnt !== 32'd0)  begin n_fail++; $display("FAIL rst_en_cnt: got %0d, required 0", en_cnt); end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_rst_n !== 1'b0 || state !== 2'b00 || core_en !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_hold: %0d early-release cycles, required 0", bad); end
    tick();
    n_tests++; if (core_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_release: core_rst_n=%b, required 1", core_rst_n); end
    n_tests++; if (state !== 2'b01)     begin n_fail++; $display("FAIL rst_to_halt: state=%b, required 01", state); end
    bad = 0;
    repeat (20) begin tick(); if (core_en !== 1'b0) bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL halt_no_en: %0d pulses, required 0", bad); end
  endtask

  task automatic test_run_rate();
    int npulse, last, first, bad_gap;
    logic [3:0] expv;
    div_sel = 2'b01; mode = 2'b00;
    do_reset();
    mode = 2'b01;
    npulse = 0; last = -1; first = -1; bad_gap = 0;
    for (int m = 1; m <= 200; m++) begin
      tick();
      if (core_en === 1'b1) begin
        if (last < 0) first = m;
        else if (m - last != 32) bad_gap++;
        last = m;
        npulse++;
      end
    end
    n_tests++; if (first != 32)  begin n_fail++; $display("FAIL run_first: first pulse at %0d, required 32", first); end
    n_tests++; if (bad_gap != 0) begin n_fail++; $display("FAIL run_gap: %0d bad gaps, required 0", bad_gap); end
    n_tests++; if (npulse != 6)  begin n_fail++; $display("FAIL run_pulses: got %0d, required 6", npulse); end
    n_tests++; if (en_cnt !== 32'd6) begin n_fail++; $display("FAIL run_en_cnt: got %0d, required 6", en_cnt); end
    div_sel = 2'b00;
    expv = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (core_en !== expv[i]) begin
        n_fail++;
        $display("FAIL div_switch[%0d]: core_en=%b, required %b", i, core_en, expv[i]);
      end
    end
  endtask

  task automatic test_step();
    logic [39:0] pat;
    int nstep, nen, step_at, en_at, bad;
    mode = 2'b10; div_sel = 2'b00; step_btn = 1'b0;
    do_reset();
    pat = 40'h000000FFC9;
    nstep = 0; nen = 0; step_at = -10; en_at = -20;
    for (int i = 0; i < 40; i++) begin
      step_btn = pat[i];
      tick();
      if (state === 2'b11) begin nstep++; step_at = i; end
      if (core_en === 1'b1) begin nen++; en_at = i; end
    end
    n_tests++; if (nstep != 1) begin n_fail++; $display("FAIL step_visits: got %0d, required 1", nstep); end
    n_tests++; if (nen != 1)   begin n_fail++; $display("FAIL step_pulses: got %0d, required 1", nen); end
    n_tests++; if (en_at != step_at + 1) begin n_fail++; $display("FAIL step_latency: en at %0d, required %0d", en_at, step_at + 1); end
    n_tests++; if (en_cnt !== 32'd1) begin n_fail++; $display("FAIL step_en_cnt: got %0d, required 1", en_cnt); end
    bad = 0; nen = 0;
    for (int i = 0; i < 22; i++) begin
      step_btn = (i < 2);
      tick();
      if (core_en === 1'b1) nen++;
      if (state !== 2'b01) bad++;
    end
    n_tests++; if (nen != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d, required 0", nen); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL glitch_state: %0d non-HALT cycles, required 0", bad); end
  endtask

  task automatic test_halt_with_step();
    int nstep, nen;
    mode = 2'b10; step_btn = 1'b0; halt_req = 1'b0;
    do_reset();
    halt_req = 1'b1;
    nstep = 0; nen = 0;
    for (int i = 0; i < 20; i++) begin
      step_btn = (i < 10);
      tick();
      if (state === 2'b11) nstep++;
      if (core_en === 1'b1) nen++;
    end
    halt_req = 1'b0;
    n_tests++; if (nstep != 0 || nen != 0) begin n_fail++; $display("FAIL halt_step_drop: steps=%0d pulses=%0d, required 0 0", nstep, nen); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_step_flag: halted=%b, required 1", halted); end
    mode = 2'b00;
    tick();
  endtask

  task automatic test_halt();
    int nen, bad;
    bit found;
    div_sel = 2'b00; mode = 2'b01; halt_req = 1'b0;
    do_reset();
    repeat (10) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL halt_state: got %b, required 01", state); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b, required 1", halted); end
    n_tests++; if (core_en !== 1'b0) begin n_fail++; $display("FAIL halt_exit_en: got %b, required 0", core_en); end
    nen = 0; bad = 0;
    repeat (20) begin
      tick();
      if (core_en === 1'b1) nen++;
      if (state !== 2'b01) bad++;
    end
    n_tests++; if (nen != 0 || bad != 0) begin n_fail++; $display("FAIL halt_sticky: pulses=%0d nonhalt=%0d, required 0 0", nen, bad); end
    mode = 2'b00;
    tick();
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b, required 0", halted); end
    mode = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (core_en === 1'b1) found = 1'b1;
    end
    n_tests++; if (!found || state !== 2'b10) begin n_fail++; $display("FAIL halt_resume: found=%b state=%b, required 1 10", found, state); end
  endtask

  task automatic test_rst_mid_run();
    bit found;
    div_sel = 2'b00; mode = 2'b01;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (core_en === 1'b1) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL midrst_setup: core_en=0, required a pulse within 10 cycles"); end
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (core_en !== 1'b0)    begin n_fail++; $display("FAIL midrst_en: got %b, required 0", core_en); end
    n_tests++; if (core_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrst_core_rst_n: got %b, required 0", core_rst_n); end
    n_tests++; if (en_cnt !== 32'd0)    begin n_fail++; $display("FAIL midrst_en_cnt: got %0d, required 0", en_cnt); end
    n_tests++; if (state !== 2'b00)     begin n_fail++; $display("FAIL midrst_state: got %b, required 00", state); end
    rst = 1'b1;
  endtask

  task automatic test_wrap();
    bit found;
    mode = 2'b00; div_sel = 2'b00;
    do_reset();
    force dut.en_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.en_cnt;
    tick();
    n_tests++; if (en_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h, required ffffffff", en_cnt); end
    mode = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (core_en === 1'b1) found = 1'b1;
    end
    tick();
    n_tests++; if (!found || en_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap: found=%b en_cnt=%h, required 1 00000000", found, en_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_rate();
    test_step();
    test_halt_with_step();
    test_halt();
    test_rst_mid_run();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
